// File: rtl/encoder_index_ctrl_if.sv
// rtl/encoder_index_ctrl_if.sv - encoder index supervisor signal bundle
interface encoder_index_ctrl_if;
    logic        Z;
    logic [31:0] counter;
    logic [31:0] pulses_per_rev_bits;
    logic        arm;
    logic        clear_fault;
    logic        homed;
    logic        fault;
    logic        index_pulse;
    logic [31:0] index_ref;
    logic [31:0] last_delta;
    logic [15:0] err_count;
    logic [1:0]  state;

    modport master (
        output Z, counter, pulses_per_rev_bits, arm, clear_fault,
        input  homed, fault, index_pulse, index_ref, last_delta, err_count, state
    );

    modport slave (
        input  Z, counter, pulses_per_rev_bits, arm, clear_fault,
        output homed, fault, index_pulse, index_ref, last_delta, err_count, state
    );
endinterface

// File: rtl/encoder_index_ctrl.sv
// rtl/encoder_index_ctrl.sv - encoder index homing/lock supervisor
// Optional watchdog in SEEK/VERIFY enabled by macro ENCODER_INDEX_TIMEOUT_EN.
module encoder_index_ctrl #(
    parameter int unsigned TOL            = 4,
    parameter int unsigned MAX_ERR        = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    encoder_index_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEEK, S_VERIFY, S_LOCKED, S_FAULT} state_t;

    state_t st, st_nx;

    logic        z_s1, z_s2, z_s3;
    logic        z_rise;
    logic [31:0] capture, prev_capture, delta, abs_delta, rev;
    logic signed [32:0] dev;
    logic        good, nonzero;
    logic [7:0]  streak;
    logic [31:0] index_ref_r, last_delta_r;
    logic [15:0] err_r;
    logic        ld_ref, ld_eval, err_inc, streak_inc, streak_clr, clr_stats;
    logic        streak_full, to_set;

    assign z_rise    = z_s2 & ~z_s3;
    assign capture   = bus.counter;
    assign delta     = capture - prev_capture;
    assign nonzero   = (delta != 32'd0);
    assign abs_delta = delta[31] ? (~delta + 32'd1) : delta;
    assign rev       = 32'd1 << bus.pulses_per_rev_bits[4:0];
    // 33-bit signed so a short delta gives a negative deviation, not a wrap
    assign dev       = $signed({1'b0, abs_delta}) - $signed({1'b0, rev});
    assign good      = (dev <= $signed(33'(TOL))) && (dev >= -$signed(33'(TOL)));
    assign streak_full = (32'(streak) + 32'd1) >= 32'(MAX_ERR);

`ifdef ENCODER_INDEX_TIMEOUT_EN
    logic [31:0] wd;
    logic        timeout_flag;
    logic        wd_hit;
    assign wd_hit = (wd >= TIMEOUT_CYCLES - 32'd1);
`endif

    always_comb begin
        st_nx      = st;
        ld_ref     = 1'b0;
        ld_eval    = 1'b0;
        err_inc    = 1'b0;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        clr_stats  = 1'b0;
        to_set     = 1'b0;
        if (st == S_FAULT && bus.clear_fault) begin
            st_nx = S_IDLE;
        end else if (bus.arm) begin
            st_nx     = S_SEEK;
            clr_stats = 1'b1;
        end else begin
            case (st)
                S_SEEK: begin
                    if (z_rise) begin
                        ld_ref = 1'b1;
                        st_nx  = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (z_rise && nonzero) begin
                        ld_eval = 1'b1;
                        if (good) st_nx = S_LOCKED;
                        else      err_inc = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (z_rise && nonzero) begin
                        ld_eval = 1'b1;
                        if (good) begin
                            streak_clr = 1'b1;
                        end else begin
                            err_inc    = 1'b1;
                            streak_inc = 1'b1;
                            if (streak_full) st_nx = S_FAULT;
                        end
                    end
                end
                default: ;
            endcase
`ifdef ENCODER_INDEX_TIMEOUT_EN
            if ((st == S_SEEK || st == S_VERIFY) && !z_rise && wd_hit) begin
                st_nx  = S_FAULT;
                to_set = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_s1            <= 1'b0;
            z_s2            <= 1'b0;
            z_s3            <= 1'b0;
            prev_capture    <= 32'd0;
            index_ref_r     <= 32'd0;
            last_delta_r    <= 32'd0;
            err_r           <= 16'd0;
            streak          <= 8'd0;
            bus.index_pulse <= 1'b0;
            bus.homed       <= 1'b0;
            bus.fault       <= 1'b0;
            bus.state       <= 2'd0;
        end else begin
            z_s1 <= bus.Z;
            z_s2 <= z_s1;
            z_s3 <= z_s2;
            // An index coincident with arm is dropped entirely, strobe included
            bus.index_pulse <= z_rise & ~bus.arm;
            bus.homed       <= (st_nx == S_LOCKED);
            bus.fault       <= (st_nx == S_FAULT);
            case (st_nx)
                S_IDLE:             bus.state <= 2'd0;
                S_SEEK:             bus.state <= 2'd1;
                S_VERIFY, S_LOCKED: bus.state <= 2'd2;
                default:            bus.state <= 2'd3;
            endcase
            if (ld_ref) begin
                index_ref_r  <= capture;
                prev_capture <= capture;
            end
            if (ld_eval) begin
                last_delta_r <= delta;
                prev_capture <= capture;
            end
            if (clr_stats) begin
                err_r  <= 16'd0;
                streak <= 8'd0;
            end else begin
                if (err_inc && err_r != 16'hFFFF) err_r <= err_r + 16'd1;
                if (streak_clr)                   streak <= 8'd0;
                else if (streak_inc && streak != 8'hFF) streak <= streak + 8'd1;
            end
        end
    end

`ifdef ENCODER_INDEX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd           <= 32'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (bus.arm || z_rise)                 wd <= 32'd0;
            else if (st == S_SEEK || st == S_VERIFY) wd <= wd + 32'd1;
            else                                   wd <= 32'd0;
            if (clr_stats)   timeout_flag <= 1'b0;
            else if (to_set) timeout_flag <= 1'b1;
        end
    end
    assign bus.last_delta = timeout_flag ? 32'h8000_0000 : last_delta_r;
`else
    assign bus.last_delta = last_delta_r;
`endif

    assign bus.index_ref = index_ref_r;
    assign bus.err_count = err_r;
endmodule

// File: tb/tb_encoder_index_ctrl.sv
// tb/tb_encoder_index_ctrl.sv - scoreboard bench for encoder_index_ctrl
module tb_encoder_index_ctrl;
    localparam int TOL     = 4;
    localparam int MAX_ERR = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    encoder_index_ctrl_if bus ();

    encoder_index_ctrl #(.TOL(TOL), .MAX_ERR(MAX_ERR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  st;
        logic        homed;
        logic        fault;
        logic [15:0] err;
        logic [31:0] last;
        logic [31:0] iref;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: 0 idle, 1 seek, 2 verify, 3 locked, 4 fault
    int          m_mode = 0;
    logic [31:0] m_prev = 0, m_last = 0, m_ref = 0;
    int          m_err = 0, m_streak = 0, m_bits = 12;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_snap();
        exp_t e;
        e.st    = (m_mode == 0) ? 2'd0 : (m_mode == 1) ? 2'd1 : (m_mode == 4) ? 2'd3 : 2'd2;
        e.homed = (m_mode == 3);
        e.fault = (m_mode == 4);
        e.err   = 16'(m_err);
        e.last  = m_last;
        e.iref  = m_ref;
        return e;
    endfunction

    task automatic model_index(input logic [31:0] c);
        int     d;
        longint ad, rv;
        bit     ok;
        if (m_mode == 1) begin
            m_ref  = c;
            m_prev = c;
            m_mode = 2;
        end else if (m_mode == 2 || m_mode == 3) begin
            d = int'(c - m_prev);
            if (d != 0) begin
                ad = (d < 0) ? -longint'(d) : longint'(d);
                rv = longint'(1) << m_bits;
                ok = ((ad - rv) <= TOL) && ((ad - rv) >= -TOL);
                m_last = c - m_prev;
                m_prev = c;
                if (ok) begin
                    if (m_mode == 2) m_mode = 3;
                    m_streak = 0;
                end else begin
                    if (m_err < 65535) m_err++;
                    if (m_mode == 3) begin
                        m_streak++;
                        if (m_streak >= MAX_ERR) m_mode = 4;
                    end
                end
            end
        end
    endtask

    task automatic z_index(input logic [31:0] c);
        model_index(c);
        sb.push_back(model_snap());
        @(negedge clk);
        bus.counter = c;
        bus.Z = 1'b1;
        repeat (4) @(negedge clk);
        bus.Z = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_arm(input int bits);
        @(negedge clk);
        bus.pulses_per_rev_bits = 32'(bits);
        m_bits = bits;
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        m_mode = 1; m_err = 0; m_streak = 0;
        chk("arm_state", 32'(bus.state), 32'd1);
        chk("arm_err", 32'(bus.err_count), 32'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
        if (m_mode == 4) m_mode = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.index_pulse) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: index_pulse=1 expected none at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_state", 32'(bus.state), 32'(e.st));
                chk("sb_homed", 32'(bus.homed), 32'(e.homed));
                chk("sb_fault", 32'(bus.fault), 32'(e.fault));
                chk("sb_err", 32'(bus.err_count), 32'(e.err));
                chk("sb_last_delta", bus.last_delta, e.last);
                chk("sb_index_ref", bus.index_ref, e.iref);
            end
        end
    end

    initial begin
        logic [31:0] c;
        int          r, off, bits;
        bus.Z = 1'b0; bus.counter = 0; bus.pulses_per_rev_bits = 12;
        bus.arm = 1'b0; bus.clear_fault = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_homed", 32'(bus.homed), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_ref", bus.index_ref, 32'd0);
        chk("rst_last", bus.last_delta, 32'd0);
        chk("rst_err", 32'(bus.err_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_arm(12);
        z_index(32'd20);
        z_index(32'd4116);
        chk("locked_homed", 32'(bus.homed), 32'd1);
        z_index(32'd20);
        z_index(32'd20);
        z_index(32'd4110);
        z_index(32'd8200);
        z_index(32'd12290);
        chk("fault_flag", 32'(bus.fault), 32'd1);
        chk("fault_err", 32'(bus.err_count), 32'd3);
        z_index(32'd16380);
        do_clear();
        chk("clear_state", 32'(bus.state), 32'd0);
        chk("clear_fault", 32'(bus.fault), 32'd0);

        do_arm(12);
        z_index(32'hFFFF_FF00);
        z_index(32'h0000_0F00);
        chk("wrap_homed", 32'(bus.homed), 32'd1);
        chk("wrap_last", bus.last_delta, 32'd4096);

        for (int i = 0; i < 60; i++) begin
            if (m_mode == 4) begin
                do_clear();
                bits = $urandom_range(8, 14);
                do_arm(bits);
                z_index($urandom);
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                c = m_prev;
            end else if (r <= 2) begin
                off = $urandom_range(TOL + 1, 40);
                if ($urandom_range(0, 1) == 1) off = -off;
                c = m_prev + 32'((1 << m_bits) + off);
            end else begin
                off = $urandom_range(0, 2 * TOL) - TOL;
                c = m_prev + 32'((1 << m_bits) + off);
            end
            if ($urandom_range(0, 3) == 0) c = m_prev - (c - m_prev);
            z_index(c);
        end

        // Arm lands on the same edge as an index rise: index dropped, SEEK entered
        @(negedge clk);
        bus.counter = 32'h1234;
        bus.Z = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.arm = 1'b1;
        bus.pulses_per_rev_bits = 12;
        @(negedge clk);
        bus.arm = 1'b0;
        m_mode = 1; m_err = 0; m_streak = 0; m_bits = 12;
        chk("coinc_state", 32'(bus.state), 32'd1);
        chk("coinc_ref", bus.index_ref, m_ref);
        repeat (3) @(negedge clk);
        bus.Z = 1'b0;
        repeat (4) @(negedge clk);
        z_index(32'h1000_0000);
        z_index(32'h1000_1003);

        repeat (10) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_homed", 32'(bus.homed), 32'd0);
        chk("midrst_ref", bus.index_ref, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
